// File: rtl/sfx_player.sv
// Sound-effect sequencer: plays a fixed note sequence per game event as a square wave.
// Optional mute control is compiled in with `define SFX_MUTE_EN.
module sfx_player #(
    parameter int TICK_DIV = 25000,
    parameter int HALF_W   = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_eat,
    input  logic       i_failure,
    input  logic       i_success,
`ifdef SFX_MUTE_EN
    input  logic       i_mute_toggle,
    output logic       o_muted,
`endif
    output logic       o_audio,
    output logic       o_busy,
    output logic [1:0] o_effect
);

    localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PLAY = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]        r_state;
    logic              r_armed;
    logic [2:0]        r_in_q;
    logic [2:0]        r_in_qq;
    logic [PRE_W-1:0]  r_pre;
    logic [6:0]        r_dur;
    logic [HALF_W-1:0] r_half;
    logic [1:0]        r_note;
    logic              r_audio;
    logic              r_busy;
    logic [1:0]        r_effect;

    logic [2:0]        w_in;
    logic [2:0]        w_rise;
    logic [1:0]        w_new_eff;
    logic              w_fire;
    logic              w_tick;
    logic [HALF_W+7:0] w_note;
    logic [HALF_W-1:0] w_half;
    logic [6:0]        w_dur;
    logic              w_last;
    logic              w_mute;

    // Packed entry {last, duration ticks, half-period cycles}.
    function automatic logic [HALF_W+7:0] note_entry(input logic [1:0] eff, input logic [1:0] idx);
        logic [HALF_W-1:0] h;
        logic [6:0]        d;
        logic              l;
        h = '0;
        d = 7'd1;
        l = 1'b1;
        case (eff)
            2'd1: begin
                d = 7'd40;
                l = (idx == 2'd1);
                h = (idx == 2'd0) ? HALF_W'(12000) : HALF_W'(9000);
            end
            2'd2: begin
                d = 7'd80;
                l = (idx == 2'd3);
                case (idx)
                    2'd0:    h = HALF_W'(12000);
                    2'd1:    h = HALF_W'(10000);
                    2'd2:    h = HALF_W'(8000);
                    default: h = HALF_W'(6000);
                endcase
            end
            2'd3: begin
                d = 7'd120;
                l = (idx == 2'd2);
                case (idx)
                    2'd0:    h = HALF_W'(16000);
                    2'd1:    h = HALF_W'(20000);
                    default: h = HALF_W'(24000);
                endcase
            end
            default: ;
        endcase
        return {l, d, h};
    endfunction

    assign w_in   = {i_failure, i_success, i_eat};
    assign w_rise = r_in_q & ~r_in_qq;
    assign w_note = note_entry(r_effect, r_note);
    assign w_half = w_note[HALF_W-1:0];
    assign w_dur  = w_note[HALF_W+6:HALF_W];
    assign w_last = w_note[HALF_W+7];
    assign w_tick = (r_pre == PRE_LAST);

    always_comb begin
        w_new_eff = 2'd0;
        if (w_rise[2])      w_new_eff = 2'd3;
        else if (w_rise[1]) w_new_eff = 2'd2;
        else if (w_rise[0]) w_new_eff = 2'd1;
    end

    // Equal priority restarts the current effect; lower priority is dropped.
    assign w_fire = (w_new_eff != 2'd0) && (w_new_eff >= r_effect);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_armed  <= 1'b0;
            r_in_q   <= '0;
            r_in_qq  <= '0;
            r_pre    <= '0;
            r_dur    <= '0;
            r_half   <= '0;
            r_note   <= '0;
            r_audio  <= 1'b0;
            r_busy   <= 1'b0;
            r_effect <= '0;
        end else begin
            // First clock after reset loads both stages so held-high inputs do not fire.
            r_armed <= 1'b1;
            r_in_q  <= w_in;
            r_in_qq <= r_armed ? r_in_q : w_in;
            if (w_fire) begin
                r_state  <= S_PLAY;
                r_effect <= w_new_eff;
                r_busy   <= 1'b1;
                r_note   <= '0;
                r_pre    <= '0;
                r_dur    <= '0;
                r_half   <= '0;
                r_audio  <= 1'b0;
            end else begin
                case (r_state)
                    S_PLAY: begin
                        r_pre <= w_tick ? '0 : r_pre + 1'b1;
                        if (r_half == w_half - 1'b1) begin
                            r_half  <= '0;
                            r_audio <= ~r_audio;
                        end else begin
                            r_half <= r_half + 1'b1;
                        end
                        if (w_tick) begin
                            if (r_dur == w_dur - 7'd1) begin
                                r_state <= S_GAP;
                                r_dur   <= '0;
                                r_half  <= '0;
                                r_audio <= 1'b0;
                            end else begin
                                r_dur <= r_dur + 7'd1;
                            end
                        end
                    end
                    S_GAP: begin
                        r_pre <= w_tick ? '0 : r_pre + 1'b1;
                        if (w_tick) begin
                            if (w_last) begin
                                r_state  <= S_IDLE;
                                r_busy   <= 1'b0;
                                r_effect <= '0;
                                r_note   <= '0;
                            end else begin
                                r_state <= S_PLAY;
                                r_note  <= r_note + 2'd1;
                                r_dur   <= '0;
                                r_half  <= '0;
                                r_audio <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_pre <= '0;
                    end
                endcase
            end
        end
    end

`ifdef SFX_MUTE_EN
    logic r_mute_q;
    logic r_mute_qq;
    logic r_muted;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mute_q  <= 1'b0;
            r_mute_qq <= 1'b0;
            r_muted   <= 1'b0;
        end else begin
            r_mute_q  <= i_mute_toggle;
            r_mute_qq <= r_armed ? r_mute_q : i_mute_toggle;
            if (r_mute_q && !r_mute_qq)
                r_muted <= ~r_muted;
        end
    end

    assign w_mute  = r_muted;
    assign o_muted = r_muted;
`else
    assign w_mute = 1'b0;
`endif

    assign o_audio  = r_audio & ~w_mute;
    assign o_busy   = r_busy;
    assign o_effect = r_effect;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player: fast instance (TICK_DIV=8) for sequencing, slow one for waveform.
module tb_sfx_player;

    logic clk = 1'b0;
    logic rst;
    logic f_eat, f_fail, f_succ, f_audio, f_busy;
    logic [1:0] f_eff;
    logic s_eat, s_fail, s_succ, s_audio, s_busy;
    logic [1:0] s_eff;
`ifdef SFX_MUTE_EN
    logic f_mute, f_muted, s_mute, s_muted;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    sfx_player #(.TICK_DIV(8), .HALF_W(15)) u_fast (
        .clk(clk), .rst(rst),
        .i_eat(f_eat), .i_failure(f_fail), .i_success(f_succ),
`ifdef SFX_MUTE_EN
        .i_mute_toggle(f_mute), .o_muted(f_muted),
`endif
        .o_audio(f_audio), .o_busy(f_busy), .o_effect(f_eff)
    );

    sfx_player #(.TICK_DIV(320), .HALF_W(15)) u_slow (
        .clk(clk), .rst(rst),
        .i_eat(s_eat), .i_failure(s_fail), .i_success(s_succ),
`ifdef SFX_MUTE_EN
        .i_mute_toggle(s_mute), .o_muted(s_muted),
`endif
        .o_audio(s_audio), .o_busy(s_busy), .o_effect(s_eff)
    );

    typedef struct {
        string name;
        bit    eat;
        bit    succ;
        bit    fail;
        int    eff;
        int    len;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic pulse_fast(input bit e, input bit s, input bit f);
        f_eat = e; f_succ = s; f_fail = f;
        @(negedge clk);
        f_eat = 1'b0; f_succ = 1'b0; f_fail = 1'b0;
    endtask

    task automatic wait_fast_busy(output int n);
        n = 0;
        while (!f_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic count_fast_busy(output int n);
        n = 0;
        while (f_busy && n < 5000) begin
            n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int lat, len, n, bad, hi;
        int r1, f1, r2;

        vecs[0] = '{"eat",          1, 0, 0, 1, 656};
        vecs[1] = '{"success",      0, 1, 0, 2, 2592};
        vecs[2] = '{"failure",      0, 0, 1, 3, 2904};
        vecs[3] = '{"eat+success",  1, 1, 0, 2, 2592};
        vecs[4] = '{"eat+failure",  1, 0, 1, 3, 2904};
        vecs[5] = '{"all three",    1, 1, 1, 3, 2904};
        vecs[6] = '{"succ+failure", 0, 1, 1, 3, 2904};

        rst = 1'b1;
        f_eat = 0; f_fail = 0; f_succ = 0;
        s_eat = 0; s_fail = 0; s_succ = 0;
`ifdef SFX_MUTE_EN
        f_mute = 0; s_mute = 0;
`endif
        repeat (3) @(negedge clk);
        chk("reset audio", f_audio, 0);
        chk("reset busy", f_busy, 0);
        chk("reset effect", f_eff, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single-cycle events from idle: latency, chosen effect, total busy time.
        foreach (vecs[i]) begin
            pulse_fast(vecs[i].eat, vecs[i].succ, vecs[i].fail);
            wait_fast_busy(lat);
            chk({vecs[i].name, " latency"}, lat, 1);
            chk({vecs[i].name, " effect"}, f_eff, vecs[i].eff);
            count_fast_busy(len);
            chk({vecs[i].name, " busy len"}, len, vecs[i].len);
            chk({vecs[i].name, " idle effect"}, f_eff, 0);
            repeat (4) @(negedge clk);
        end

        // Eat note 0 then gap: still busy with eat, audio low at the gap start.
        pulse_fast(1, 0, 0);
        wait_fast_busy(lat);
        repeat (320) @(negedge clk);
        chk("eat gap audio", f_audio, 0);
        chk("eat gap busy", f_busy, 1);
        chk("eat gap effect", f_eff, 1);
        count_fast_busy(len);
        chk("eat remaining", len, 336);
        repeat (4) @(negedge clk);

        // Failure pre-empts eat mid-note and then stays high.
        pulse_fast(1, 0, 0);
        wait_fast_busy(lat);
        repeat (100) @(negedge clk);
        f_fail = 1'b1;
        n = 0;
        while (f_eff != 2'd3 && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("preempt latency", n, 2);
        chk("preempt audio", f_audio, 0);
        count_fast_busy(len);
        chk("preempt busy len", len, 2904);
        hi = 0;
        repeat (2100) begin
            @(negedge clk);
            if (f_busy) hi++;
        end
        chk("held failure retrigger", hi, 0);
        f_fail = 1'b0;
        repeat (3) @(negedge clk);
        f_fail = 1'b1;
        n = 0;
        while (!f_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("failure re-rise latency", n, 2);
        chk("failure re-rise effect", f_eff, 3);

        // Async reset mid-note with failure held through release.
        repeat (500) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async rst audio", f_audio, 0);
        chk("async rst busy", f_busy, 0);
        chk("async rst effect", f_eff, 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        hi = 0;
        repeat (50) begin
            @(negedge clk);
            if (f_busy) hi++;
        end
        chk("held through reset", hi, 0);
        f_fail = 1'b0;
        repeat (4) @(negedge clk);

        // Success playing: a later eat is dropped.
        pulse_fast(0, 1, 0);
        wait_fast_busy(lat);
        n = 0;
        bad = 0;
        while (f_busy && n < 5000) begin
            if (n == 50) f_eat = 1'b1;
            if (n == 51) f_eat = 1'b0;
            if (f_eff != 2'd2) bad++;
            n++;
            @(negedge clk);
        end
        chk("success vs eat len", n, 2592);
        chk("success vs eat effect", bad, 0);
        repeat (4) @(negedge clk);

        // Slow instance: square-wave edges of the eat sequence.
        s_eat = 1'b1;
        @(negedge clk);
        s_eat = 1'b0;
        n = 0;
        while (!s_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("slow latency", n, 1);
        r1 = -1; f1 = -1; r2 = -1;
        n = 0;
        while (s_busy && n < 30000) begin
            if (s_audio && r1 < 0) r1 = n;
            else if (!s_audio && r1 >= 0 && f1 < 0) f1 = n;
            else if (s_audio && f1 >= 0 && r2 < 0) r2 = n;
            n++;
            @(negedge clk);
        end
        chk("first toggle", r1, 12000);
        chk("note0 end audio low", f1, 12800);
        chk("note1 first toggle", r2, 22120);
        chk("slow busy len", n, 26240);

`ifdef SFX_MUTE_EN
        repeat (4) @(negedge clk);
        s_eat = 1'b1;
        @(negedge clk);
        s_eat = 1'b0;
        n = 0;
        while (!s_busy && n < 10) begin
            @(negedge clk);
            n++;
        end
        hi = 0;
        n = 0;
        while (s_busy && n < 30000) begin
            if (n == 100) s_mute = 1'b1;
            if (n == 101) s_mute = 1'b0;
            if (s_audio) hi++;
            n++;
            @(negedge clk);
        end
        chk("muted audio highs", hi, 0);
        chk("muted busy len", n, 26240);
        chk("muted flag", s_muted, 1);
        s_mute = 1'b1;
        @(negedge clk);
        s_mute = 1'b0;
        repeat (3) @(negedge clk);
        chk("unmuted flag", s_muted, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
